gb_cpu_regfile_mp: RTL and testbench
====================================

// Module: gb_cpu_regfile_mp
// PURPOSE
//  Parametrised multi-port register file for the gb CPU. Replaces the fixed ALU/IDU/data-bus writers with
//  NUM_WR prioritised write ports and NUM_RD read ports, all on a single rising clock edge.
//  Adds a masked flag-update port, a shadow bank (save/restore/exchange) and a debug scan-out FSM.
//  Sits between decode/control and the ALU/IDU/bus datapaths.
// PARAMETERS
//  NUM_WR    3        write ports; lower index = higher priority
//  NUM_RD    2        read ports
//  NUM_REGS  16       8-bit registers. Map: 0 A,1 F,2 B,3 C,4 D,5 E,6 H,7 L,8 SP_L,9 SP_H,10 PC_L,11 PC_H,12 TMP_L,13 TMP_H,14 IR,15 IE
//  PC_RESET  16'h0000 PC reset value
// PORTS
//  clk          in   1            clock, all state updates on rising edge
//  reset        in   1            synchronous, active-high
//  wr_en        in   NUM_WR       per-port write enable
//  wr_pair      in   NUM_WR       1: 16-bit write to pair {addr|1 = hi, addr&~1 = lo}
//  wr_addr      in   NUM_WR*4     register index
//  wr_data      in   NUM_WR*16    byte write uses [7:0]
//  flag_we      in   1            masked flag update
//  flag_mask    in   4            {Z,N,H,C} bits to update
//  flag_val     in   4            {Z,N,H,C} new values
//  rd_pair      in   NUM_RD       1: 16-bit read of pair
//  rd_addr      in   NUM_RD*4     read index
//  rd_data      out  NUM_RD*16    read data; byte read zero-extended
//  shadow_save  in   1            copy all regs to shadow bank
//  shadow_rest  in   1            copy shadow bank to regs
//  shadow_valid out  1            shadow holds saved data
//  dbg_req      in   1            start register scan-out
//  dbg_valid    out  1            dbg_data valid
//  dbg_idx      out  4            index of register in dbg_data
//  dbg_data     out  8            scanned register value
//  dbg_last     out  1            final scan beat
// BEHAVIOUR
//  - Reset: all regs 0 except PC={PC_RESET}; shadow bank 0; shadow_valid=0; FSM IDLE; dbg_* outputs 0.
//  - Writes take effect at the next rising edge. Per byte, the lowest-indexed enabled port targeting it wins.
//    Pair write: lo byte <= data[7:0], hi byte <= data[15:8]; addr[0] ignored.
//  - F[3:0] always reads 0; writes to those bits are dropped.
//  - flag_we: F[7:4] bits with mask=1 <= flag_val, others hold. Any port write to F overrides flag_we that cycle.
//  - Update priority, highest first: shadow_rest > port writes > flag_we > hold.
//  - shadow_save alone: shadow <= current regs (pre-write values); shadow_valid <= 1; port writes still apply.
//  - shadow_rest with shadow_valid=1: regs <= shadow; port writes and flag_we dropped; shadow_valid <= 0.
//  - shadow_rest with shadow_valid=0: no effect; writes proceed.
//  - save+rest same cycle with valid=1: exchange (regs<->shadow); shadow_valid stays 1.
//  - Reads: combinational from the register array; pair read = {reg[addr|1], reg[addr&~1]}.
//  - Debug FSM:
//    IDLE --dbg_req--> SCAN, idx=0.
//    SCAN: one register per cycle; dbg_valid=1, dbg_idx=idx, dbg_data=live reg[idx]; dbg_last=(idx==NUM_REGS-1).
//    The last beat returns to IDLE. Latency dbg_req -> first beat: 1 cycle. dbg_req during SCAN is ignored.
//    Reset mid-scan aborts immediately, with dbg_valid=0 on the next cycle.
//  - Scan reflects writes committed before each beat; writes never stall.
// CONFIGURATION
//  GB_REGFILE_BYPASS_EN defined: rd_data forwards same-cycle winning write data per byte (write-through),
//    including the flag merge and the shadow restore value.
//  Undefined: rd_data shows committed state only; a new value is visible the cycle after the write.
// TESTING
//  - reset -> A..L,SP,TMP,IR,IE=0; PC=PC_RESET; shadow_valid=0; dbg_valid=0.
//  - port0 wr A=8'h11 and port2 wr A=8'h22, same cycle -> A=8'h11.
//    port1 pair wr addr 2, data 16'hBEEF -> B=BE, C=EF.
//  - F=8'hF0, flag_we mask=4'b0101 val=4'b0000 -> F=8'hA0. Port wr F=8'hFF plus flag_we same cycle -> F=8'hF0.
//  - A=1, save; A=2; restore -> A=1, valid=0.
//    Save with A=3, then A=4, then save+rest -> A=3, shadow A=4, valid=1.
//  - dbg_req after reset -> 16 beats idx 0..15, PC beats = PC_RESET bytes, dbg_last on beat 16.
//    Reset asserted at beat 5 -> scan stops.
//  - Bypass: wr A=8'h5A, rd A same cycle -> 8'h5A with GB_REGFILE_BYPASS_EN, old value without; 8'h5A next cycle in both.

Source files
------------

// File: rtl/gb_cpu_regfile_mp.sv
// gb CPU register file: prioritised write ports, masked flag update, shadow bank, debug scan-out.
// Optional write-through read forwarding is enabled by defining GB_REGFILE_BYPASS_EN.
module gb_cpu_regfile_mp #(
    parameter int unsigned NUM_WR   = 3,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned NUM_REGS = 16,
    parameter logic [15:0] PC_RESET = 16'h0000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_WR-1:0]      i_wr_en,
    input  logic [NUM_WR-1:0]      i_wr_pair,
    input  logic [NUM_WR*4-1:0]    i_wr_addr,
    input  logic [NUM_WR*16-1:0]   i_wr_data,
    input  logic                   i_flag_we,
    input  logic [3:0]             i_flag_mask,
    input  logic [3:0]             i_flag_val,
    input  logic [NUM_RD-1:0]      i_rd_pair,
    input  logic [NUM_RD*4-1:0]    i_rd_addr,
    output logic [NUM_RD*16-1:0]   o_rd_data,
    input  logic                   i_shadow_save,
    input  logic                   i_shadow_rest,
    output logic                   o_shadow_valid,
    input  logic                   i_dbg_req,
    output logic                   o_dbg_valid,
    output logic [3:0]             o_dbg_idx,
    output logic [7:0]             o_dbg_data,
    output logic                   o_dbg_last
);

    localparam int unsigned RegF   = 1;
    localparam int unsigned RegPcL = 10;
    localparam int unsigned RegPcH = 11;

    typedef enum logic {StIdle, StScan} dbg_state_e;

    logic [7:0]          r_regs   [NUM_REGS];
    logic [7:0]          r_shadow [NUM_REGS];
    logic [7:0]          w_next   [NUM_REGS];
    logic [7:0]          w_rd_src [NUM_REGS];
    logic [NUM_REGS-1:0] w_hit;
    logic [3:0]          w_ra     [NUM_RD];
    logic                w_restore;
    logic                r_shadow_valid;
    dbg_state_e          r_dbg_state;
    logic [3:0]          w_dbg_next_idx;

    assign w_restore      = i_shadow_rest && r_shadow_valid;
    assign o_shadow_valid = r_shadow_valid;
    assign w_dbg_next_idx = o_dbg_idx + 4'd1;

    // Ports are scanned high index first so the lowest-indexed port lands last and wins.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            w_hit[r]  = 1'b0;
            w_next[r] = r_regs[r];
            for (int p = NUM_WR - 1; p >= 0; p--) begin
                if (i_wr_en[p]) begin
                    if (i_wr_pair[p] && ((i_wr_addr[p*4 +: 4] | 4'd1) == 4'(r))) begin
                        w_hit[r]  = 1'b1;
                        w_next[r] = i_wr_data[p*16 + 8 +: 8];
                    end else if (i_wr_pair[p] && ((i_wr_addr[p*4 +: 4] & 4'hE) == 4'(r))) begin
                        w_hit[r]  = 1'b1;
                        w_next[r] = i_wr_data[p*16 +: 8];
                    end else if (!i_wr_pair[p] && (i_wr_addr[p*4 +: 4] == 4'(r))) begin
                        w_hit[r]  = 1'b1;
                        w_next[r] = i_wr_data[p*16 +: 8];
                    end
                end
            end
            if (r == RegF) begin
                if (w_hit[r]) begin
                    w_next[r] = w_next[r] & 8'hF0;
                end else if (i_flag_we) begin
                    w_next[r] = {(i_flag_mask & i_flag_val) | (~i_flag_mask & r_regs[r][7:4]),
                                 4'h0};
                end
            end
            if (w_restore) begin
                w_next[r] = r_shadow[r];
            end
        end
    end

`ifdef GB_REGFILE_BYPASS_EN
    assign w_rd_src = w_next;
`else
    assign w_rd_src = r_regs;
`endif

    // Odd index holds the high byte of a pair.
    always_comb begin
        o_rd_data = '0;
        for (int q = 0; q < NUM_RD; q++) begin
            w_ra[q] = i_rd_addr[q*4 +: 4];
            if (i_rd_pair[q]) begin
                o_rd_data[q*16 +: 16] = {w_rd_src[w_ra[q] | 4'd1], w_rd_src[w_ra[q] & 4'hE]};
            end else begin
                o_rd_data[q*16 +: 16] = {8'h00, w_rd_src[w_ra[q]]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                r_regs[r]   <= (r == RegPcL) ? PC_RESET[7:0] :
                               (r == RegPcH) ? PC_RESET[15:8] : 8'h00;
                r_shadow[r] <= 8'h00;
            end
            r_shadow_valid <= 1'b0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                r_regs[r] <= w_next[r];
            end
            if (i_shadow_save) begin
                for (int r = 0; r < NUM_REGS; r++) begin
                    r_shadow[r] <= r_regs[r];
                end
                r_shadow_valid <= 1'b1;
            end else if (w_restore) begin
                r_shadow_valid <= 1'b0;
            end
        end
    end

    // Beat data is captured from the next-state value so it equals the live register in that beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_dbg_state <= StIdle;
            o_dbg_valid <= 1'b0;
            o_dbg_idx   <= 4'd0;
            o_dbg_data  <= 8'h00;
            o_dbg_last  <= 1'b0;
        end else begin
            case (r_dbg_state)
                StIdle: begin
                    if (i_dbg_req) begin
                        r_dbg_state <= StScan;
                        o_dbg_valid <= 1'b1;
                        o_dbg_idx   <= 4'd0;
                        o_dbg_data  <= w_next[0];
                        o_dbg_last  <= (NUM_REGS == 1);
                    end
                end
                StScan: begin
                    if (o_dbg_last) begin
                        r_dbg_state <= StIdle;
                        o_dbg_valid <= 1'b0;
                        o_dbg_idx   <= 4'd0;
                        o_dbg_data  <= 8'h00;
                        o_dbg_last  <= 1'b0;
                    end else begin
                        o_dbg_idx   <= w_dbg_next_idx;
                        o_dbg_data  <= w_next[w_dbg_next_idx];
                        o_dbg_last  <= (w_dbg_next_idx == 4'(NUM_REGS - 1));
                    end
                end
                default: r_dbg_state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_gb_cpu_regfile_mp.sv
// Directed self-checking bench for gb_cpu_regfile_mp (PC_RESET overridden to 16'h0150).
module tb_gb_cpu_regfile_mp;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  wr_en, wr_pair;
    logic [11:0] wr_addr;
    logic [47:0] wr_data;
    logic        flag_we;
    logic [3:0]  flag_mask, flag_val;
    logic [1:0]  rd_pair;
    logic [7:0]  rd_addr;
    logic [31:0] rd_data;
    logic        shadow_save, shadow_rest, shadow_valid;
    logic        dbg_req, dbg_valid, dbg_last;
    logic [3:0]  dbg_idx;
    logic [7:0]  dbg_data;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    gb_cpu_regfile_mp #(
        .NUM_WR(3), .NUM_RD(2), .NUM_REGS(16), .PC_RESET(16'h0150)
    ) dut (
        .clk(clk), .reset(reset),
        .i_wr_en(wr_en), .i_wr_pair(wr_pair), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
        .i_flag_we(flag_we), .i_flag_mask(flag_mask), .i_flag_val(flag_val),
        .i_rd_pair(rd_pair), .i_rd_addr(rd_addr), .o_rd_data(rd_data),
        .i_shadow_save(shadow_save), .i_shadow_rest(shadow_rest), .o_shadow_valid(shadow_valid),
        .i_dbg_req(dbg_req), .o_dbg_valid(dbg_valid), .o_dbg_idx(dbg_idx),
        .o_dbg_data(dbg_data), .o_dbg_last(dbg_last)
    );

    task automatic clear_ctl();
        wr_en = '0; wr_pair = '0; wr_addr = '0; wr_data = '0;
        flag_we = 1'b0; flag_mask = '0; flag_val = '0;
        shadow_save = 1'b0; shadow_rest = 1'b0; dbg_req = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        clear_ctl();
    endtask

    task automatic wr(input int p, input logic pr, input logic [3:0] a, input logic [15:0] d);
        wr_en[p] = 1'b1;
        wr_pair[p] = pr;
        wr_addr[p*4 +: 4] = a;
        wr_data[p*16 +: 16] = d;
    endtask

    task automatic rd(input int p, input logic pr, input logic [3:0] a, output logic [15:0] d);
        rd_pair[p] = pr;
        rd_addr[p*4 +: 4] = a;
        #1;
        d = rd_data[p*16 +: 16];
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [15:0] d;
        logic [7:0]  e;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            e = (i == 10) ? 8'h50 : (i == 11) ? 8'h01 : 8'h00;
            rd(0, 1'b0, 4'(i), d);
            n_checks++;
            if (d !== {8'h00, e}) begin
                n_errors++;
                $display("FAIL reset_reg%0d got=%h exp=%h", i, d, {8'h00, e});
            end
        end
        rd(1, 1'b1, 4'd10, d);
        n_checks++;
        if (d !== 16'h0150) begin
            n_errors++; $display("FAIL reset_pc_pair got=%h exp=0150", d);
        end
        n_checks++;
        if (shadow_valid !== 1'b0 || dbg_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_flags got sv=%b dv=%b exp 0 0", shadow_valid, dbg_valid);
        end
    endtask

    task automatic test_priority();
        logic [15:0] d;
        wr(0, 1'b0, 4'd0, 16'h0011);
        wr(2, 1'b0, 4'd0, 16'h0022);
        wr(1, 1'b1, 4'd2, 16'hBEEF);
        tick();
        rd(0, 1'b0, 4'd0, d);
        n_checks++;
        if (d !== 16'h0011) begin n_errors++; $display("FAIL prio_a got=%h exp=0011", d); end
        rd(0, 1'b0, 4'd2, d);
        n_checks++;
        if (d !== 16'h00EF) begin n_errors++; $display("FAIL pair_lo got=%h exp=00ef", d); end
        rd(0, 1'b0, 4'd3, d);
        n_checks++;
        if (d !== 16'h00BE) begin n_errors++; $display("FAIL pair_hi got=%h exp=00be", d); end
        rd(1, 1'b1, 4'd2, d);
        n_checks++;
        if (d !== 16'hBEEF) begin n_errors++; $display("FAIL pair_rd got=%h exp=beef", d); end
        // Byte-level contention: port0 owns reg3, port1 pair (addr[0] ignored) gets reg2.
        wr(0, 1'b0, 4'd3, 16'h0077);
        wr(1, 1'b1, 4'd3, 16'h1234);
        tick();
        rd(1, 1'b1, 4'd3, d);
        n_checks++;
        if (d !== 16'h7734) begin n_errors++; $display("FAIL byte_prio got=%h exp=7734", d); end
        wr(2, 1'b0, 4'd1, 16'h00FF);
        tick();
        rd(0, 1'b0, 4'd1, d);
        n_checks++;
        if (d !== 16'h00F0) begin n_errors++; $display("FAIL f_low got=%h exp=00f0", d); end
    endtask

    task automatic test_flags();
        logic [15:0] d;
        flag_we = 1'b1; flag_mask = 4'b0101; flag_val = 4'b0000;
        tick();
        rd(0, 1'b0, 4'd1, d);
        n_checks++;
        if (d !== 16'h00A0) begin n_errors++; $display("FAIL flag_mask got=%h exp=00a0", d); end
        wr(1, 1'b0, 4'd1, 16'h00FF);
        flag_we = 1'b1; flag_mask = 4'b1111; flag_val = 4'b0000;
        tick();
        rd(0, 1'b0, 4'd1, d);
        n_checks++;
        if (d !== 16'h00F0) begin n_errors++; $display("FAIL flag_ovr got=%h exp=00f0", d); end
        flag_we = 1'b1; flag_mask = 4'b1000; flag_val = 4'b0000;
        tick();
        flag_we = 1'b1; flag_mask = 4'b0001; flag_val = 4'b0000;
        tick();
        rd(0, 1'b0, 4'd1, d);
        n_checks++;
        if (d !== 16'h0060) begin n_errors++; $display("FAIL flag_seq got=%h exp=0060", d); end
    endtask

    task automatic test_shadow();
        logic [15:0] d;
        wr(0, 1'b0, 4'd0, 16'h0001);
        tick();
        shadow_save = 1'b1;
        wr(0, 1'b0, 4'd2, 16'h0055);
        tick();
        rd(0, 1'b0, 4'd2, d);
        n_checks++;
        if (d !== 16'h0055 || shadow_valid !== 1'b1) begin
            n_errors++; $display("FAIL save_wr got=%h sv=%b exp=0055 1", d, shadow_valid);
        end
        wr(0, 1'b0, 4'd0, 16'h0002);
        tick();
        shadow_rest = 1'b1;
        wr(0, 1'b0, 4'd0, 16'h0099);
        flag_we = 1'b1; flag_mask = 4'b1111; flag_val = 4'b1111;
        tick();
        rd(0, 1'b0, 4'd0, d);
        n_checks++;
        if (d !== 16'h0001 || shadow_valid !== 1'b0) begin
            n_errors++; $display("FAIL restore_a got=%h sv=%b exp=0001 0", d, shadow_valid);
        end
        rd(0, 1'b0, 4'd2, d);
        n_checks++;
        if (d !== 16'h0034) begin n_errors++; $display("FAIL restore_pre got=%h exp=0034", d); end
        rd(0, 1'b0, 4'd1, d);
        n_checks++;
        if (d !== 16'h0060) begin n_errors++; $display("FAIL restore_f got=%h exp=0060", d); end
        shadow_rest = 1'b1;
        wr(0, 1'b0, 4'd0, 16'h0042);
        tick();
        rd(0, 1'b0, 4'd0, d);
        n_checks++;
        if (d !== 16'h0042 || shadow_valid !== 1'b0) begin
            n_errors++; $display("FAIL rest_invalid got=%h sv=%b exp=0042 0", d, shadow_valid);
        end
        wr(0, 1'b0, 4'd0, 16'h0003);
        tick();
        shadow_save = 1'b1;
        tick();
        wr(0, 1'b0, 4'd0, 16'h0004);
        tick();
        shadow_save = 1'b1; shadow_rest = 1'b1;
        tick();
        rd(0, 1'b0, 4'd0, d);
        n_checks++;
        if (d !== 16'h0003 || shadow_valid !== 1'b1) begin
            n_errors++; $display("FAIL exchange got=%h sv=%b exp=0003 1", d, shadow_valid);
        end
        shadow_rest = 1'b1;
        tick();
        rd(0, 1'b0, 4'd0, d);
        n_checks++;
        if (d !== 16'h0004 || shadow_valid !== 1'b0) begin
            n_errors++; $display("FAIL exch_shadow got=%h sv=%b exp=0004 0", d, shadow_valid);
        end
    endtask

    task automatic test_debug();
        logic [7:0] e;
        do_reset();
        dbg_req = 1'b1;
        tick();
        for (int b = 0; b < 16; b++) begin
            e = (b == 10) ? 8'h50 : (b == 11) ? 8'h01 : (b == 4) ? 8'hC4 :
                (b == 6) ? 8'h66 : 8'h00;
            n_checks++;
            if ({dbg_valid, dbg_idx, dbg_data, dbg_last} !== {1'b1, 4'(b), e, (b == 15)}) begin
                n_errors++;
                $display("FAIL dbg_beat%0d got v=%b i=%0d d=%h l=%b exp v=1 i=%0d d=%h l=%b",
                         b, dbg_valid, dbg_idx, dbg_data, dbg_last, b, e, (b == 15));
            end
            if (b == 2) wr(0, 1'b0, 4'd4, 16'h00C4);
            if (b == 3) dbg_req = 1'b1;
            if (b == 5) wr(1, 1'b0, 4'd6, 16'h0066);
            tick();
        end
        n_checks++;
        if (dbg_valid !== 1'b0 || dbg_last !== 1'b0) begin
            n_errors++; $display("FAIL dbg_end got v=%b l=%b exp 0 0", dbg_valid, dbg_last);
        end
        dbg_req = 1'b1;
        tick();
        repeat (5) tick();
        n_checks++;
        if (dbg_valid !== 1'b1 || dbg_idx !== 4'd5) begin
            n_errors++; $display("FAIL dbg_beat5 got v=%b i=%0d exp 1 5", dbg_valid, dbg_idx);
        end
        reset = 1'b1;
        tick();
        n_checks++;
        if (dbg_valid !== 1'b0 || dbg_idx !== 4'd0) begin
            n_errors++; $display("FAIL dbg_abort got v=%b i=%0d exp 0 0", dbg_valid, dbg_idx);
        end
        reset = 1'b0;
        tick();
        n_checks++;
        if (dbg_valid !== 1'b0) begin
            n_errors++; $display("FAIL dbg_idle got v=%b exp 0", dbg_valid);
        end
    endtask

    task automatic test_bypass();
        logic [15:0] d;
        logic [15:0] e_a, e_f;
`ifdef GB_REGFILE_BYPASS_EN
        e_a = 16'h005A; e_f = 16'h00A0;
`else
        e_a = 16'h0000; e_f = 16'h0000;
`endif
        wr(0, 1'b0, 4'd0, 16'h005A);
        flag_we = 1'b1; flag_mask = 4'b1111; flag_val = 4'b1010;
        rd(0, 1'b0, 4'd0, d);
        n_checks++;
        if (d !== e_a) begin n_errors++; $display("FAIL byp_a got=%h exp=%h", d, e_a); end
        rd(1, 1'b0, 4'd1, d);
        n_checks++;
        if (d !== e_f) begin n_errors++; $display("FAIL byp_f got=%h exp=%h", d, e_f); end
        tick();
        rd(0, 1'b0, 4'd0, d);
        n_checks++;
        if (d !== 16'h005A) begin n_errors++; $display("FAIL byp_next got=%h exp=005a", d); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        rd_pair = '0;
        rd_addr = '0;
        clear_ctl();
        test_reset();
        test_priority();
        test_flags();
        test_shadow();
        test_debug();
        test_bypass();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
